multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/mips_ctrl_pkg.sv | 45 ++++
 rtl/ctrl_out_decode.sv | 90 +++++++++
 rtl/multicycle_control_unit.sv | 141 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, ALU-op
// codes, mux select encodings and the FSM state enum.
package mips_ctrl_pkg;

    // Opcode field values of the supported instructions
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation requested from the ALU control block
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Encodings 12..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode for the multicycle control unit. Everything depends on
// the state alone, except the FETCH write strobes which wait for mem_ready.
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op
);

    // Per-state control word; anything not named for a state stays 0
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: state register and next-state logic live here,
// the per-state control word comes from ctrl_out_decode.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int EN_ADDI  = 1,
    parameter int EN_JUMP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal_op,
    output logic [3:0]          state
);

    state_e state_q;
    state_e state_d;

    logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, op_legal;

    assign is_rtype = (opcode == OPCODE_W'(OP_RTYPE));
    assign is_lw    = (opcode == OPCODE_W'(OP_LW));
    assign is_sw    = (opcode == OPCODE_W'(OP_SW));
    assign is_beq   = (opcode == OPCODE_W'(OP_BEQ));
    assign is_addi  = (opcode == OPCODE_W'(OP_ADDI)) && (EN_ADDI != 0);
    assign is_j     = (opcode == OPCODE_W'(OP_J)) && (EN_JUMP != 0);
    assign op_legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states stall until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (is_lw || is_sw)  state_d = MEMADR;
                else if (is_rtype)   state_d = EXEC;
                else if (is_beq)     state_d = BRANCH;
                else if (is_addi)    state_d = ADDIEX;
                else if (is_j)       state_d = JUMP;
                else                 state_d = FETCH;
            end
            MEMADR: state_d = is_sw ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = RWB;
            RWB:    state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    logic       dec_pc_write, dec_pc_write_cond, dec_iord, dec_mem_read;
    logic       dec_mem_write, dec_ir_write, dec_mem_to_reg, dec_reg_dst;
    logic       dec_reg_write, dec_alu_src_a;
    logic [1:0] dec_alu_src_b, dec_pc_source, dec_alu_op;

    ctrl_out_decode u_decode (
        .state         (state_q),
        .mem_ready     (mem_ready),
        .pc_write      (dec_pc_write),
        .pc_write_cond (dec_pc_write_cond),
        .iord          (dec_iord),
        .mem_read      (dec_mem_read),
        .mem_write     (dec_mem_write),
        .ir_write      (dec_ir_write),
        .mem_to_reg    (dec_mem_to_reg),
        .reg_dst       (dec_reg_dst),
        .reg_write     (dec_reg_write),
        .alu_src_a     (dec_alu_src_a),
        .alu_src_b     (dec_alu_src_b),
        .pc_source     (dec_pc_source),
        .alu_op        (dec_alu_op)
    );

    // Outputs are held quiet while in reset, even though the state reads FETCH
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = '0;
        illegal_op    = 1'b0;
        if (rst_n) begin
            pc_write      = dec_pc_write;
            pc_write_cond = dec_pc_write_cond;
            iord          = dec_iord;
            mem_read      = dec_mem_read;
            mem_write     = dec_mem_write;
            ir_write      = dec_ir_write;
            mem_to_reg    = dec_mem_to_reg;
            reg_dst       = dec_reg_dst;
            reg_write     = dec_reg_write;
            alu_src_a     = dec_alu_src_a;
            alu_src_b     = dec_alu_src_b;
            pc_source     = dec_pc_source;
            alu_op        = ALUOP_W'(dec_alu_op);
            // DECODE lasts exactly one cycle, so this is a single-cycle pulse
            illegal_op    = (state_q == DECODE) && !op_legal;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction state/control
// sequences, memory stalls, illegal opcodes, mid-instruction reset and a
// random sweep for read/write exclusivity.
module tb_multicycle_control_unit;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n_nj = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic [3:0] state;

    logic       nj_pc_write, nj_pc_write_cond, nj_iord, nj_mem_read, nj_mem_write, nj_ir_write;
    logic       nj_mem_to_reg, nj_reg_dst, nj_reg_write, nj_alu_src_a, nj_illegal_op;
    logic [1:0] nj_alu_src_b, nj_pc_source, nj_alu_op;
    logic [3:0] nj_state;

    int total = 0;
    int bad = 0;

    // {illegal_op, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op}
    logic [16:0] word, word_nj;
    assign word = {illegal_op, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};
    assign word_nj = {nj_illegal_op, nj_pc_write, nj_pc_write_cond, nj_iord, nj_mem_read,
                      nj_mem_write, nj_ir_write, nj_mem_to_reg, nj_reg_dst, nj_reg_write,
                      nj_alu_src_a, nj_alu_src_b, nj_pc_source, nj_alu_op};

    // Hand-derived control words per state
    localparam logic [16:0] W_ZERO   = 17'h00000;
    localparam logic [16:0] W_FETCH1 = 17'h09410;
    localparam logic [16:0] W_FETCH0 = 17'h01010;
    localparam logic [16:0] W_DECODE = 17'h00030;
    localparam logic [16:0] W_DECILL = 17'h10030;
    localparam logic [16:0] W_MEMADR = 17'h00060;
    localparam logic [16:0] W_MEMRD  = 17'h03000;
    localparam logic [16:0] W_MEMWB  = 17'h00280;
    localparam logic [16:0] W_MEMWR  = 17'h02800;
    localparam logic [16:0] W_EXEC   = 17'h00042;
    localparam logic [16:0] W_RWB    = 17'h00180;
    localparam logic [16:0] W_BRANCH = 17'h04045;
    localparam logic [16:0] W_ADDIEX = 17'h00060;
    localparam logic [16:0] W_ADDIWB = 17'h00080;
    localparam logic [16:0] W_JUMP   = 17'h08008;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
    );

    multicycle_control_unit #(.EN_JUMP(0)) dut_nj (
        .clk(clk), .rst_n(rst_n_nj), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(nj_pc_write), .pc_write_cond(nj_pc_write_cond), .iord(nj_iord),
        .mem_read(nj_mem_read), .mem_write(nj_mem_write), .ir_write(nj_ir_write),
        .mem_to_reg(nj_mem_to_reg), .reg_dst(nj_reg_dst), .reg_write(nj_reg_write),
        .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b), .pc_source(nj_pc_source),
        .alu_op(nj_alu_op), .illegal_op(nj_illegal_op), .state(nj_state)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        mem_ready = 1'b1;
        #1;
        total++;
        if (state !== FETCH || word !== W_ZERO) begin
            bad++;
            $display("FAIL reset: got state=%0d ctl=%h, expected state=%0d ctl=%h", state, word, FETCH, W_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (state !== FETCH || word !== W_FETCH0) begin
                bad++;
                $display("FAIL fetch_hold cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, FETCH, W_FETCH0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4];
        logic [16:0] ew [4];
        es = '{FETCH, DECODE, EXEC, RWB};
        ew = '{W_FETCH1, W_DECODE, W_EXEC, W_RWB};
        opcode = 6'b000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL rtype cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0]  es [8];
        logic [16:0] ew [8];
        logic        mr [8];
        es = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMRD, MEMWB};
        ew = '{W_FETCH1, W_DECODE, W_MEMADR, W_MEMRD, W_MEMRD, W_MEMRD, W_MEMRD, W_MEMWB};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL lw_stall cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw();
        logic [3:0]  es [4];
        logic [16:0] ew [4];
        es = '{FETCH, DECODE, MEMADR, MEMWR};
        ew = '{W_FETCH1, W_DECODE, W_MEMADR, W_MEMWR};
        opcode = 6'b101011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL sw cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        logic [3:0]  es [3];
        logic [16:0] ew [3];
        es = '{FETCH, DECODE, BRANCH};
        ew = '{W_FETCH1, W_DECODE, W_BRANCH};
        opcode = 6'b000100;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL beq cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_addi();
        logic [3:0]  es [4];
        logic [16:0] ew [4];
        es = '{FETCH, DECODE, ADDIEX, ADDIWB};
        ew = '{W_FETCH1, W_DECODE, W_ADDIEX, W_ADDIWB};
        opcode = 6'b001000;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL addi cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        logic [3:0]  es [3];
        logic [16:0] ew [3];
        es = '{FETCH, DECODE, JUMP};
        ew = '{W_FETCH1, W_DECODE, W_JUMP};
        opcode = 6'b000010;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL jump cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_opcode();
        logic [3:0]  es [3];
        logic [16:0] ew [3];
        logic        mr [3];
        es = '{FETCH, DECODE, FETCH};
        ew = '{W_FETCH1, W_DECILL, W_FETCH0};
        mr = '{1'b1, 1'b1, 1'b0};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL illegal_op cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump_disabled();
        logic [3:0]  es [3];
        logic [16:0] ew [3];
        logic        mr [3];
        es = '{FETCH, DECODE, FETCH};
        ew = '{W_FETCH1, W_DECILL, W_FETCH0};
        mr = '{1'b1, 1'b1, 1'b0};
        rst_n = 1'b0;
        rst_n_nj = 1'b1;
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (nj_state !== es[i] || word_nj !== ew[i]) begin
                bad++;
                $display("FAIL jump_disabled cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, nj_state, word_nj, es[i], ew[i]);
            end
            @(negedge clk);
        end
        rst_n_nj = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sw();
        logic [3:0]  es [5];
        logic [16:0] ew [5];
        logic        mr [5];
        es = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR};
        ew = '{W_FETCH1, W_DECODE, W_MEMADR, W_MEMWR, W_MEMWR};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== es[i] || word !== ew[i]) begin
                bad++;
                $display("FAIL sw_stall cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, es[i], ew[i]);
            end
            if (i < 4) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== FETCH || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL sw_abort: got state=%0d mem_write=%b, expected state=%0d mem_write=0", state, mem_write, FETCH);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== FETCH || word !== W_FETCH0) begin
                bad++;
                $display("FAIL sw_after_abort cyc%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, state, word, FETCH, W_FETCH0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [5:0] legal [6];
        logic [5:0] op;
        logic       is_legal;
        int         pulses;
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        pulses = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 1) == 1) op = legal[$urandom_range(0, 5)];
            else op = 6'($urandom);
            opcode = op;
            mem_ready = 1'($urandom_range(0, 1));
            is_legal = 1'b0;
            for (int k = 0; k < 6; k++) if (op == legal[k]) is_legal = 1'b1;
            #1;
            total++;
            if ((mem_read && mem_write) !== 1'b0) begin
                bad++;
                $display("FAIL rand_rw_excl n%0d: got mem_read=%b mem_write=%b, expected not both 1", n, mem_read, mem_write);
            end
            total++;
            if (illegal_op === 1'b1 && is_legal) begin
                bad++;
                $display("FAIL rand_illegal n%0d: got illegal_op=1 on opcode=%b, expected 0", n, op);
            end
            if (illegal_op === 1'b1) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses == 0) begin
            bad++;
            $display("FAIL rand_illegal_seen: got %0d pulses, expected at least 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_beq();
        test_addi();
        test_jump();
        test_illegal_opcode();
        test_jump_disabled();
        test_reset_mid_sw();
        test_sw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
